// File: rtl/forwarding_stall_unit.sv
// forwarding_stall_unit
// Operand-bypass select and load-use stall generator for the ID stage.
// Compares every ID source against the destinations of NUM_FWD producer
// stages (stage 0 = EX, higher index = older). The youngest match wins.
// A load in EX that feeds an ID source freezes the front end for LOAD_LAT cycles.
// Optional feature: define HAZARD_PERF_CNT_EN to add a saturating 32-bit
// stall_cnt output that counts the cycles in which stall was high.
module forwarding_stall_unit #(
  parameter int REG_AW   = 5,
  parameter int NUM_SRC  = 2,
  parameter int NUM_FWD  = 3,
  parameter int LOAD_LAT = 1,
  localparam int SELW    = $clog2(NUM_FWD + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        id_valid,
  input  logic [NUM_SRC*REG_AW-1:0]   id_rs,
  input  logic [NUM_SRC-1:0]          id_rs_used,
  input  logic [NUM_FWD*REG_AW-1:0]   stg_rd,
  input  logic [NUM_FWD-1:0]          stg_wen,
  input  logic                        ex_is_load,
  input  logic                        flush,
  output logic [NUM_SRC*SELW-1:0]     fwd_sel,
  output logic                        stall
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]                 stall_cnt
`endif
);

  localparam logic [2:0] CNT_INIT = 3'(LOAD_LAT - 1);

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  state_t                     state;
  state_t                     state_next;
  logic [2:0]                 cnt;
  logic [2:0]                 cnt_next;
  logic [NUM_SRC*SELW-1:0]    sel_next;
  logic                       ex_match;
  logic                       load_use_hit;

  // Per-source bypass select; stages are scanned oldest to youngest so the youngest match overwrites
  always_comb begin
    sel_next = '0;
    ex_match = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = NUM_FWD - 1; k >= 0; k--) begin
        if (id_valid && id_rs_used[i] && stg_wen[k] &&
            (stg_rd[k*REG_AW +: REG_AW] != '0) &&
            (stg_rd[k*REG_AW +: REG_AW] == id_rs[i*REG_AW +: REG_AW])) begin
          sel_next[i*SELW +: SELW] = SELW'(k + 1);
          if (k == 0) begin
            ex_match = 1'b1;
          end
        end
      end
    end
  end

  assign load_use_hit = ex_match && ex_is_load;

  // Stall FSM state and remaining-hold counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic: the hit cycle is the first stall cycle, HOLD supplies the remaining LOAD_LAT-1
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    if (flush) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (load_use_hit && (LOAD_LAT > 1)) begin
            state_next = HOLD;
            cnt_next   = CNT_INIT;
          end
        end
        HOLD: begin
          cnt_next = cnt - 3'd1;
          if (cnt <= 3'd1) begin
            state_next = IDLE;
            cnt_next   = '0;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // Stall output: suppressed by reset and flush, otherwise the hit in IDLE or unconditional in HOLD
  always_comb begin
    stall = 1'b0;
    if (reset && !flush) begin
      case (state)
        IDLE:    stall = load_use_hit;
        HOLD:    stall = 1'b1;
        default: stall = 1'b0;
      endcase
    end
  end

  // Registered selects; a stalled or flushed cycle sends a bubble to EX, so nothing is bypassed
  always_ff @(posedge clk) begin
    if (!reset || flush || stall) begin
      fwd_sel <= '0;
    end else begin
      fwd_sel <= sel_next;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Saturating count of stalled cycles
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_forwarding_stall_unit.sv
// Testbench for forwarding_stall_unit (NUM_SRC=3, NUM_FWD=5, LOAD_LAT=3).
// Directed hazard scenarios followed by a random sweep; expected selects are
// queued when each cycle's stimulus is driven and compared after the edge.
module tb_forwarding_stall_unit;

  localparam int AW  = 5;
  localparam int SRC = 3;
  localparam int FWD = 5;
  localparam int LAT = 3;
  localparam int SW  = $clog2(FWD + 1);

  logic                clk = 1'b0;
  logic                reset;
  logic                id_valid;
  logic [SRC*AW-1:0]   id_rs;
  logic [SRC-1:0]      id_rs_used;
  logic [FWD*AW-1:0]   stg_rd;
  logic [FWD-1:0]      stg_wen;
  logic                ex_is_load;
  logic                flush;
  logic [SRC*SW-1:0]   fwd_sel;
  logic                stall;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]         stall_cnt;
  logic [31:0]         cnt_m;
`endif

  int                  checks = 0;
  int                  errors = 0;
  int                  rem    = 0;
  logic                last_stall;
  logic [SRC*SW-1:0]   exp_q[$];

  forwarding_stall_unit #(
    .REG_AW  (AW),
    .NUM_SRC (SRC),
    .NUM_FWD (FWD),
    .LOAD_LAT(LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .id_valid  (id_valid),
    .id_rs     (id_rs),
    .id_rs_used(id_rs_used),
    .stg_rd    (stg_rd),
    .stg_wen   (stg_wen),
    .ex_is_load(ex_is_load),
    .flush     (flush),
    .fwd_sel   (fwd_sel),
    .stall     (stall)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  // 10-time-unit clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Reference: first (youngest) matching stage per source, plus the EX load-use hit
  function automatic void modelComb(output logic [SRC*SW-1:0] sel, output logic hit);
    sel = '0;
    hit = 1'b0;
    for (int i = 0; i < SRC; i++) begin
      for (int k = 0; k < FWD; k++) begin
        logic [AW-1:0] rs;
        logic [AW-1:0] rd;
        rs = id_rs[i*AW +: AW];
        rd = stg_rd[k*AW +: AW];
        if (id_valid && id_rs_used[i] && stg_wen[k] && (rd != '0) && (rd == rs)) begin
          sel[i*SW +: SW] = SW'(k + 1);
          if (k == 0) hit = 1'b1;
          break;
        end
      end
    end
    hit = hit && ex_is_load;
  endfunction

  // Drive one cycle, check stall before the edge and the queued select after it
  task automatic applyStimulus(input string tag, input logic v, input logic [SRC*AW-1:0] rs,
                               input logic [SRC-1:0] used, input logic [FWD*AW-1:0] rd,
                               input logic [FWD-1:0] wen, input logic ld, input logic fl,
                               input logic rst);
    logic [SRC*SW-1:0] sel_m;
    logic [SRC*SW-1:0] sel_exp;
    logic              hit_m;
    logic              stall_m;
    id_valid   = v;
    id_rs      = rs;
    id_rs_used = used;
    stg_rd     = rd;
    stg_wen    = wen;
    ex_is_load = ld;
    flush      = fl;
    reset      = rst;
    #1;
    modelComb(sel_m, hit_m);
    stall_m    = rst && !fl && ((rem > 0) || hit_m);
    last_stall = stall;
    checkOutput({tag, " stall"}, 32'(stall), 32'(stall_m));
    exp_q.push_back((!rst || fl || stall_m) ? '0 : sel_m);
    if (!rst || fl) rem = 0;
    else if (rem > 0) rem = rem - 1;
    else if (hit_m) rem = LAT - 1;
`ifdef HAZARD_PERF_CNT_EN
    if (!rst) cnt_m = '0;
    else if (stall_m && (cnt_m != 32'hFFFF_FFFF)) cnt_m = cnt_m + 32'd1;
`endif
    @(posedge clk);
    #1;
    sel_exp = exp_q.pop_front();
    checkOutput({tag, " fwd_sel"}, 32'(fwd_sel), 32'(sel_exp));
`ifdef HAZARD_PERF_CNT_EN
    checkOutput({tag, " stall_cnt"}, stall_cnt, cnt_m);
`endif
  endtask

  // Directed scenarios, then the random sweep
  initial begin
    logic [FWD*AW-1:0] rd_ld;
    logic [SRC*AW-1:0] rs_ld;
    rd_ld = {5'd0, 5'd0, 5'd0, 5'd0, 5'd9};
    rs_ld = {5'd0, 5'd9, 5'd0};

    $display("[TB] reset");
    applyStimulus("rst", 1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    applyStimulus("rst", 1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("rst sel", 32'(fwd_sel), 32'd0);
    checkOutput("rst stall", 32'(last_stall), 32'd0);

    $display("[TB] basic forwarding");
    applyStimulus("basic", 1'b1, {5'd0, 5'd7, 5'd3}, 3'b011, {5{5'd3}}, 5'b11111, 1'b0, 1'b0, 1'b1);
    checkOutput("basic sel0", 32'(fwd_sel[2:0]), 32'd1);
    checkOutput("basic sel1", 32'(fwd_sel[5:3]), 32'd0);
    checkOutput("basic stall", 32'(last_stall), 32'd0);

    applyStimulus("zero", 1'b1, {5'd0, 5'd5, 5'd0}, 3'b011, {5'd1, 5'd2, 5'd5, 5'd4, 5'd0},
                  5'b11111, 1'b0, 1'b0, 1'b1);
    checkOutput("zero sel0", 32'(fwd_sel[2:0]), 32'd0);
    checkOutput("stage2 sel1", 32'(fwd_sel[5:3]), 32'd3);

    applyStimulus("order", 1'b1, {5'd1, 5'd5, 5'd4}, 3'b111, {5'd1, 5'd4, 5'd5, 5'd4, 5'd0},
                  5'b11111, 1'b0, 1'b0, 1'b1);
    checkOutput("order sel0", 32'(fwd_sel[2:0]), 32'd2);
    checkOutput("order sel2", 32'(fwd_sel[8:6]), 32'd5);

    $display("[TB] load-use stall");
    applyStimulus("ld1", 1'b1, rs_ld, 3'b010, rd_ld, 5'b00001, 1'b1, 1'b0, 1'b1);
    checkOutput("ld1 stall", 32'(last_stall), 32'd1);
    applyStimulus("ld2", 1'b1, rs_ld, 3'b010, rd_ld, 5'b00000, 1'b0, 1'b0, 1'b1);
    checkOutput("ld2 stall", 32'(last_stall), 32'd1);
    checkOutput("ld2 sel", 32'(fwd_sel), 32'd0);
    applyStimulus("ld3", 1'b1, rs_ld, 3'b010, rd_ld, 5'b00000, 1'b0, 1'b0, 1'b1);
    checkOutput("ld3 stall", 32'(last_stall), 32'd1);
    applyStimulus("ld4", 1'b1, rs_ld, 3'b010, rd_ld, 5'b00001, 1'b0, 1'b0, 1'b1);
    checkOutput("ld4 stall", 32'(last_stall), 32'd0);
    checkOutput("ld4 sel1", 32'(fwd_sel[5:3]), 32'd1);
`ifdef HAZARD_PERF_CNT_EN
    checkOutput("ld stall_cnt", stall_cnt, 32'd3);
`endif

    $display("[TB] flush during stall");
    applyStimulus("fl1", 1'b1, rs_ld, 3'b010, rd_ld, 5'b00001, 1'b1, 1'b0, 1'b1);
    checkOutput("fl1 stall", 32'(last_stall), 32'd1);
    applyStimulus("fl2", 1'b1, rs_ld, 3'b010, rd_ld, 5'b00001, 1'b1, 1'b1, 1'b1);
    checkOutput("fl2 stall", 32'(last_stall), 32'd0);
    for (int c = 0; c < LAT; c++) begin
      applyStimulus("fl_re", 1'b1, rs_ld, 3'b010, rd_ld, 5'b00001, 1'b1, 1'b0, 1'b1);
      checkOutput("fl_re stall", 32'(last_stall), 32'd1);
    end
    applyStimulus("fl_end", 1'b1, rs_ld, 3'b010, rd_ld, 5'b00001, 1'b0, 1'b0, 1'b1);
    checkOutput("fl_end stall", 32'(last_stall), 32'd0);

    $display("[TB] reset during hold");
    applyStimulus("rh1", 1'b1, rs_ld, 3'b010, rd_ld, 5'b00001, 1'b1, 1'b0, 1'b1);
    applyStimulus("rh2", 1'b1, rs_ld, 3'b010, rd_ld, 5'b00001, 1'b1, 1'b0, 1'b0);
    checkOutput("rh2 stall", 32'(last_stall), 32'd0);
    checkOutput("rh2 sel", 32'(fwd_sel), 32'd0);
    applyStimulus("rh3", 1'b1, rs_ld, 3'b010, rd_ld, 5'b00000, 1'b0, 1'b0, 1'b1);
    checkOutput("rh3 stall", 32'(last_stall), 32'd0);
    for (int c = 0; c < LAT; c++) begin
      applyStimulus("rh_re", 1'b1, rs_ld, 3'b010, rd_ld, 5'b00001, 1'b1, 1'b0, 1'b1);
      checkOutput("rh_re stall", 32'(last_stall), 32'd1);
    end
    applyStimulus("rh_end", 1'b1, rs_ld, 3'b010, rd_ld, 5'b00000, 1'b0, 1'b0, 1'b1);
    checkOutput("rh_end stall", 32'(last_stall), 32'd0);

    $display("[TB] address zero and invalid ID");
    applyStimulus("r0", 1'b1, '0, 3'b111, '0, 5'b11111, 1'b1, 1'b0, 1'b1);
    checkOutput("r0 stall", 32'(last_stall), 32'd0);
    checkOutput("r0 sel", 32'(fwd_sel), 32'd0);
    applyStimulus("inv", 1'b0, rs_ld, 3'b010, rd_ld, 5'b00001, 1'b1, 1'b0, 1'b1);
    checkOutput("inv stall", 32'(last_stall), 32'd0);
    checkOutput("inv sel", 32'(fwd_sel), 32'd0);

    $display("[TB] random sweep");
    for (int n = 0; n < 10000; n++) begin
      logic [SRC*AW-1:0] rs_r;
      logic [FWD*AW-1:0] rd_r;
      for (int i = 0; i < SRC; i++) rs_r[i*AW +: AW] = AW'($urandom_range(0, 7));
      for (int k = 0; k < FWD; k++) rd_r[k*AW +: AW] = AW'($urandom_range(0, 7));
      applyStimulus("rand", ($urandom_range(0, 7) != 0), rs_r, SRC'($urandom), rd_r, FWD'($urandom),
                    ($urandom_range(0, 2) == 0), ($urandom_range(0, 31) == 0),
                    ($urandom_range(0, 63) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
